// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer helper for sync_fifo.
// Build option: define FIFO_COUNT_EN to expose the occupancy count port on sync_fifo.
package sync_fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_WIDTH_DEF = 3;

    // Advance a pointer by one, wrapping from depth-1 back to 0 (depth need not be a power of two)
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, synchronous write, registered read.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int PTR_W = $clog2(FIFO_DEPTH_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Storage write; contents need no reset since the pointers make them unreachable
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; holds its value when no read is accepted
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with registered read data qualified by rd_vld.
// Build option: FIFO_COUNT_EN adds the fifo_count output (registered occupancy).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [FIFO_WIDTH-1:0]             wr_data,
    input  logic                              rd_en,
    output logic                              rd_vld,
    output logic                              fifo_empty,
    output logic                              fifo_full,
`ifdef FIFO_COUNT_EN
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
`endif
    output logic [FIFO_WIDTH-1:0]             rd_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_acc, rd_acc;

    // Flags come from the pre-edge count, so a write while full is refused even if a read
    // frees a slot in the same cycle, and a read while empty never falls through a new write.
    assign wr_acc     = wr_en & ~fifo_full;
    assign rd_acc     = rd_en & ~fifo_empty;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

`ifdef FIFO_COUNT_EN
    assign fifo_count = count;
`endif

    // Pointers, occupancy and read-valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_acc;
            if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed steps plus random traffic against a queue model.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int W     = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic         rd_vld, fifo_empty, fifo_full;
    logic [W-1:0] rd_data;
`ifdef FIFO_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
`endif

    sync_fifo #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_vld     (rd_vld),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
`ifdef FIFO_COUNT_EN
        .fifo_count (fifo_count),
`endif
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // reference model: a plain queue of stored words plus the last word handed out
    logic [W-1:0] q[$];
    logic [W-1:0] exp_data;
    logic         exp_vld;
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(exp_vld));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
`ifdef FIFO_COUNT_EN
        chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
`endif
    endtask

    // one clock with the given requests; model applies the FIFO rules, then outputs are compared
    task automatic step(input string tag, input logic w, input logic [W-1:0] d, input logic r);
        bit was_full, was_empty;
        wr_en = w; wr_data = d; rd_en = r; rst = 1'b0;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk); #1;
        exp_vld = 1'b0;
        if (r && !was_empty) begin
            exp_data = q.pop_front();
            exp_vld  = 1'b1;
        end
        if (w && !was_full) q.push_back(d);
        wr_en = 1'b0; rd_en = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        wr_en = w; rd_en = r; wr_data = 3'd7; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        q.delete();
        exp_vld = 1'b0; exp_data = '0;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, rx, stall, cyc;
        bit stalled;

        // 1. reset
        do_reset("reset", 1'b0, 1'b0);

        // 2. write 0..3, read 4
        for (int k = 0; k < 4; k++) step("t2_wr", 1'b1, W'(k), 1'b0);
        for (int k = 0; k < 4; k++) begin
            step("t2_rd", 1'b0, '0, 1'b1);
            chk("t2_order", 32'(rd_data), 32'(k));
        end
        chk("t2_empty", 32'(fifo_empty), 32'd1);

        // 3. fill, overflow write dropped, drain
        for (int k = 0; k < 8; k++) step("t3_wr", 1'b1, W'(k), 1'b0);
        chk("t3_full", 32'(fifo_full), 32'd1);
        step("t3_ovf", 1'b1, 3'd5, 1'b0);
        step("t3_full_rw", 1'b1, 3'd5, 1'b1);   // read taken, write refused while full
        for (int k = 1; k < 8; k++) begin
            step("t3_rd", 1'b0, '0, 1'b1);
            chk("t3_order", 32'(rd_data), 32'(k));
        end
        chk("t3_empty", 32'(fifo_empty), 32'd1);

        // 4. read while empty, then write 6 and read it back
        step("t4_rd_empty", 1'b0, '0, 1'b1);
        step("t4_empty_rw", 1'b1, 3'd6, 1'b1);  // write taken, no fall-through
        step("t4_rd", 1'b0, '0, 1'b1);
        chk("t4_data6", 32'(rd_data), 32'd6);

        // 5. concurrent streams with a reader stall
        i = 0; rx = 0; stall = 0; stalled = 0; cyc = 0;
        while (rx < 100 && cyc < 2000) begin
            logic w, r;
            w = (i < 100) && !fifo_full;
            if (!stalled && rx == 50) begin stall = 10; stalled = 1; end
            r = (stall > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (w && q.size() < DEPTH) i++;
            step("t5", w, W'(w ? i - 1 : 0), r);
            if (exp_vld) begin
                chk("t5_seq", 32'(rd_data), 32'(rx % 8));
                rx++;
            end
            if (stall > 0) begin
                stall--;
                if (stall == 0) chk("t5_stall_full", 32'(fifo_full), 32'd1);
            end
            cyc++;
        end
        chk("t5_all_received", 32'(rx), 32'd100);

        // random traffic
        for (int k = 0; k < 300; k++)
            step("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));

        // 6. reset mid-stream with 4 entries held, requests active during reset
        do_reset("t6_pre", 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step("t6_wr", 1'b1, W'(k + 3), 1'b0);
        do_reset("t6_reset", 1'b1, 1'b1);
        step("t6_rd_empty", 1'b0, '0, 1'b1);
        step("t6_wr", 1'b1, 3'd2, 1'b0);
        step("t6_rd", 1'b0, '0, 1'b1);
        chk("t6_new_data", 32'(rd_data), 32'd2);
        step("t6_idle", 1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
